// File: rtl/wspr_sym_enc.sv
// WSPR channel-symbol encoder: K=32 r=1/2 convolutional code, bit-reversal
// interleave and sync merge, streamed as 162 tone indices into the tone RAM.
module wspr_sym_enc #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [49:0] msg,
    output logic        busy,
    output logic        done,
    output logic        sym_we,
    output logic [7:0]  sym_addr,
    output logic [7:0]  sym_dat,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] POLY0 = 32'hF2D05351;
    localparam logic [31:0] POLY1 = 32'hE4613C47;
    // Ascending range so SYNC[k] is the k-th sync bit in transmission order.
    localparam logic [0:161] SYNC = 162'b11000000100011100010_01011110000000100101_00000010110011010001_10100001101010101001_00101100011010100010_00001001001110110011_01000111000001010011_00000001101011000110_00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [49:0]    shreg_q, shreg_d;
    logic [31:0]    enc_q, enc_d;
    logic [7:0]     idx_q, idx_d;
    logic           phase_q, phase_d;
    logic [161:0]   sbuf_q, sbuf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           we_q, we_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     dat_q, dat_d;
    logic [7:0]     j;
    logic [31:0]    enc_shift;
    logic           coded;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
    endfunction

    always_ff @(negedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ENC;
            ENC:     if (idx_q == 8'hFF) state_d = WR;
            WR:      if (idx_q == 8'd161) state_d = FIN;
            default: state_d = IDLE;
        endcase
    end

    // Encoder advances only on interleave slots that land inside the 162-bit buffer.
    always_comb begin
        shreg_d   = shreg_q;
        enc_d     = enc_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        sbuf_d    = sbuf_q;
        coded     = 1'b0;
        j         = bitrev8(idx_q);
        enc_shift = {enc_q[30:0], shreg_q[49]};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = msg;
                    enc_d   = '0;
                    idx_d   = '0;
                    phase_d = 1'b0;
                    sbuf_d  = '0;
                end
            end
            ENC: begin
                idx_d = idx_q + 8'd1;
                if (j < 8'd162) begin
                    if (!phase_q) begin
                        coded   = ^(enc_shift & POLY0);
                        enc_d   = enc_shift;
                        shreg_d = {shreg_q[48:0], 1'b0};
                    end else begin
                        coded   = ^(enc_q & POLY1);
                    end
                    phase_d   = ~phase_q;
                    sbuf_d[j] = coded;
                end
            end
            WR:      idx_d = idx_q + 8'd1;
            default: ;
        endcase
    end

    // Outputs are registered from the next state so strobes align with the state.
    always_comb begin
        busy_d = (state_d == ENC) || (state_d == WR);
        done_d = (state_d == FIN);
        we_d   = (state_d == WR);
        addr_d = addr_q;
        dat_d  = dat_q;
        if (state_d == WR) begin
            addr_d = BASE_ADDR + idx_d;
            dat_d  = {6'b0, sbuf_d[idx_d], SYNC[idx_d]};
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            enc_q   <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            sbuf_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            dat_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            enc_q   <= enc_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            sbuf_q  <= sbuf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sym_we    = we_q;
    assign sym_addr  = addr_q;
    assign sym_dat   = dat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wspr_sym_enc.sv
// Bench for wspr_sym_enc: checks every symbol write against a WSPR encoder
// model built from the code/interleave/sync rules, plus timing and reset cases.
module tb_wspr_sym_enc;

    localparam logic [0:161] SYNC = 162'b11000000100011100010_01011110000000100101_00000010110011010001_10100001101010101001_00101100011010100010_00001001001110110011_01000111000001010011_00000001101011000110_00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [49:0] msg = '0;
    logic        busy_a, done_a, we_a, busy_b, done_b, we_b;
    logic [7:0]  addr_a, dat_a, addr_b, dat_b;
    logic [1:0]  st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    logic [15:0] wa_q[$];
    int          wa_cyc_q[$];
    logic [15:0] wb_q[$];
    logic [15:0] exp_q[$];

    wspr_sym_enc #(.BASE_ADDR(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg(msg),
        .busy(busy_a), .done(done_a), .sym_we(we_a), .sym_addr(addr_a),
        .sym_dat(dat_a), .dbg_state(st_a)
    );

    wspr_sym_enc #(.BASE_ADDR(8'hF0)) u_dut_f0 (
        .clk(clk), .rst_n(rst_n), .start(start), .msg(msg),
        .busy(busy_b), .done(done_b), .sym_we(we_b), .sym_addr(addr_b),
        .sym_dat(dat_b), .dbg_state(st_b)
    );

    // clock / reset
    always #10 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    // write monitor, sampled on the edge opposite the DUT's active edge
    always @(posedge clk) begin
        if (we_a === 1'b1) begin
            wa_q.push_back({addr_a, dat_a});
            wa_cyc_q.push_back(cyc);
        end
        if (we_b === 1'b1) wb_q.push_back({addr_b, dat_b});
        if (done_a === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // reference model: encode, interleave, merge sync
    task automatic build_exp(input logic [49:0] m, input logic [7:0] base);
        logic [31:0] sr;
        logic        cbits[162];
        logic        ibits[162];
        logic [7:0]  iv, jv;
        logic        b;
        int          p;
        sr = '0;
        p  = 0;
        for (int n = 0; n < 81; n++) begin
            b  = (n < 50) ? m[49 - n] : 1'b0;
            sr = {sr[30:0], b};
            cbits[p] = ^(sr & 32'hF2D05351);
            cbits[p + 1] = ^(sr & 32'hE4613C47);
            p = p + 2;
        end
        p = 0;
        for (int i = 0; i < 256; i++) begin
            iv = i[7:0];
            for (int q = 0; q < 8; q++) jv[q] = iv[7 - q];
            if (jv < 8'd162) begin
                ibits[jv] = cbits[p];
                p = p + 1;
            end
        end
        exp_q.delete();
        for (int k = 0; k < 162; k++)
            exp_q.push_back({base + k[7:0], 6'b0, ibits[k], SYNC[k]});
    endtask

    function automatic int cval(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "A" && c <= "Z") return int'(c) - int'("A") + 10;
        return 36;
    endfunction

    function automatic logic [49:0] pack_k1abc();
        longint n, m1, m;
        n  = cval(" ");
        n  = n * 36 + cval("K");
        n  = n * 10 + cval("1");
        n  = n * 27 + cval("A") - 10;
        n  = n * 27 + cval("B") - 10;
        n  = n * 27 + cval("C") - 10;
        m1 = (179 - 10 * (cval("F") - 10) - cval("4")) * 180 + 10 * (cval("N") - 10) + cval("2");
        m  = m1 * 128 + 37 + 64;
        return {n[27:0], m[21:0]};
    endfunction

    // driver: one job, optional disturbance and optional mid-run reset
    task automatic run_job(input logic [49:0] m, input bit disturb, input int abort_n,
                           output int t0, output logic busy0);
        wa_q.delete();
        wa_cyc_q.delete();
        wb_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        @(posedge clk);
        msg   = m;
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        t0    = cyc;
        busy0 = busy_a;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            if (disturb) begin
                if (n == 50) msg = {18'($urandom), 32'($urandom)};
                start = (n == 100) || (n == 300) || (n == 417);
            end
            rst_n = (n != abort_n);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_a); end
        n_tests++; if (we_a !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", we_a); end
        n_tests++; if (addr_a !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", addr_a); end
        n_tests++; if (dat_a !== 8'h00) begin n_fail++; $display("FAIL reset_dat got %h exp 00", dat_a); end
        n_tests++; if (addr_b !== 8'hF0) begin n_fail++; $display("FAIL reset_addr_f0 got %h exp f0", addr_b); end
        n_tests++; if (st_a !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", st_a); end
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_vs_start busy got %b exp 0", busy_a); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_zero_msg();
        int t0;
        logic b0;
        run_job('0, 1'b0, -1, t0, b0);
        build_exp('0, 8'h00);
        n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL zero busy_after_start got %b exp 1", b0); end
        n_tests++; if (wa_q.size() != 162) begin n_fail++; $display("FAIL zero write_count got %0d exp 162", wa_q.size()); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero done_count got %0d exp 1", done_cnt); end
        n_tests++; if (done_cyc != t0 + 418) begin n_fail++; $display("FAIL zero done_latency got %0d exp %0d", done_cyc - t0 + 1, 419); end
        if (wa_q.size() == 162) begin
            n_tests++; if (wa_cyc_q[0] != t0 + 256) begin n_fail++; $display("FAIL zero first_write_cycle got %0d exp 257", wa_cyc_q[0] - t0 + 1); end
            n_tests++; if (wa_cyc_q[161] != t0 + 417) begin n_fail++; $display("FAIL zero last_write_cycle got %0d exp 418", wa_cyc_q[161] - t0 + 1); end
            n_tests++; if (wa_q[0][7:0] !== 8'd1 || wa_q[1][7:0] !== 8'd1 || wa_q[2][7:0] !== 8'd0) begin
                n_fail++; $display("FAIL zero first_syms got %0d,%0d,%0d exp 1,1,0", wa_q[0][7:0], wa_q[1][7:0], wa_q[2][7:0]);
            end
            for (int k = 0; k < 162; k++) begin
                n_tests++;
                if (wa_q[k] !== {k[7:0], 7'b0, SYNC[k]} || wa_q[k] !== exp_q[k]) begin
                    n_fail++; $display("FAIL zero write %0d got %h exp %h", k, wa_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_msb_only();
        int t0;
        logic b0;
        run_job(50'h2_0000_0000_0000, 1'b0, -1, t0, b0);
        build_exp(50'h2_0000_0000_0000, 8'h00);
        n_tests++; if (wa_q.size() != 162) begin n_fail++; $display("FAIL msb write_count got %0d exp 162", wa_q.size()); end
        if (wa_q.size() == 162) begin
            n_tests++; if (wa_q[0][7:0] !== 8'd3) begin n_fail++; $display("FAIL msb sym0 got %0d exp 3", wa_q[0][7:0]); end
            n_tests++; if (wa_q[128][7:0] !== {6'b0, 1'b1, SYNC[128]}) begin
                n_fail++; $display("FAIL msb sym128 got %0d exp %0d", wa_q[128][7:0], 2 + SYNC[128]);
            end
            for (int k = 0; k < 162; k++) begin
                n_tests++;
                if (wa_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL msb write %0d got %h exp %h", k, wa_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_k1abc();
        int t0, bad_hi;
        logic b0;
        logic [49:0] m;
        m = pack_k1abc();
        run_job(m, 1'b0, -1, t0, b0);
        build_exp(m, 8'h00);
        n_tests++; if (wa_q.size() != 162) begin n_fail++; $display("FAIL k1abc write_count got %0d exp 162", wa_q.size()); end
        bad_hi = 0;
        foreach (wa_q[k]) if (wa_q[k][7:2] !== 6'b0) bad_hi++;
        n_tests++; if (bad_hi != 0) begin n_fail++; $display("FAIL k1abc dat_hi_nonzero got %0d writes exp 0", bad_hi); end
        if (wa_q.size() == 162)
            for (int k = 0; k < 162; k++) begin
                n_tests++;
                if (wa_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL k1abc write %0d got %h exp %h", k, wa_q[k], exp_q[k]); end
            end
    endtask

    task automatic test_random();
        int t0;
        logic b0;
        logic [49:0] m;
        for (int r = 0; r < 3; r++) begin
            m = {18'($urandom), 32'($urandom)};
            run_job(m, 1'b0, -1, t0, b0);
            build_exp(m, 8'h00);
            n_tests++; if (wa_q.size() != 162 || done_cnt != 1) begin
                n_fail++; $display("FAIL random%0d count got %0d writes %0d done exp 162 1", r, wa_q.size(), done_cnt);
            end
            if (wa_q.size() == 162)
                for (int k = 0; k < 162; k++) begin
                    n_tests++;
                    if (wa_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL random%0d write %0d got %h exp %h", r, k, wa_q[k], exp_q[k]); end
                end
        end
    endtask

    task automatic test_disturb();
        int t0;
        logic b0;
        logic [49:0] m;
        m = {18'($urandom), 32'($urandom)};
        run_job(m, 1'b1, -1, t0, b0);
        build_exp(m, 8'h00);
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL disturb done_count got %0d exp 1", done_cnt); end
        n_tests++; if (wa_q.size() != 162) begin n_fail++; $display("FAIL disturb write_count got %0d exp 162", wa_q.size()); end
        if (wa_q.size() == 162)
            for (int k = 0; k < 162; k++) begin
                n_tests++;
                if (wa_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL disturb write %0d got %h exp %h", k, wa_q[k], exp_q[k]); end
            end
    endtask

    task automatic test_reset_mid();
        int t0;
        logic b0;
        logic [49:0] m;
        m = {18'($urandom), 32'($urandom)};
        run_job(m, 1'b0, 298, t0, b0);
        build_exp(m, 8'h00);
        n_tests++; if (wa_q.size() != 44) begin n_fail++; $display("FAIL abort write_count got %0d exp 44", wa_q.size()); end
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort done_count got %0d exp 0", done_cnt); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b exp 0", busy_a); end
        for (int k = 0; k < wa_q.size() && k < 44; k++) begin
            n_tests++;
            if (wa_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL abort write %0d got %h exp %h", k, wa_q[k], exp_q[k]); end
        end
        m = {18'($urandom), 32'($urandom)};
        run_job(m, 1'b0, -1, t0, b0);
        build_exp(m, 8'h00);
        n_tests++; if (wa_q.size() != 162 || done_cnt != 1) begin
            n_fail++; $display("FAIL after_abort count got %0d writes %0d done exp 162 1", wa_q.size(), done_cnt);
        end
        if (wa_q.size() == 162)
            for (int k = 0; k < 162; k++) begin
                n_tests++;
                if (wa_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL after_abort write %0d got %h exp %h", k, wa_q[k], exp_q[k]); end
            end
    endtask

    task automatic test_base_wrap();
        int t0;
        logic b0;
        logic [49:0] m;
        m = {18'($urandom), 32'($urandom)};
        run_job(m, 1'b0, -1, t0, b0);
        build_exp(m, 8'hF0);
        n_tests++; if (wb_q.size() != 162) begin n_fail++; $display("FAIL wrap write_count got %0d exp 162", wb_q.size()); end
        if (wb_q.size() == 162) begin
            n_tests++; if (wb_q[15][15:8] !== 8'hFF) begin n_fail++; $display("FAIL wrap addr15 got %h exp ff", wb_q[15][15:8]); end
            n_tests++; if (wb_q[16][15:8] !== 8'h00) begin n_fail++; $display("FAIL wrap addr16 got %h exp 00", wb_q[16][15:8]); end
            n_tests++; if (wb_q[161][15:8] !== 8'h91) begin n_fail++; $display("FAIL wrap addr161 got %h exp 91", wb_q[161][15:8]); end
            for (int k = 0; k < 162; k++) begin
                n_tests++;
                if (wb_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL wrap write %0d got %h exp %h", k, wb_q[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_msg();
        test_msb_only();
        test_k1abc();
        test_random();
        test_disturb();
        test_reset_mid();
        test_base_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wspr_sym_enc.md
# wspr_sym_enc

WSPR channel-symbol encoder that sits directly upstream of the WSPR tone RAM feeding the modulator. It takes a packed 50-bit WSPR message (callsign, locator, power) and runs the K=32, rate-1/2 convolutional code, bit-reversal interleaving and sync-vector merge. It then writes the 162 resulting 4-FSK tone indices (0..3) into the tone RAM through its byte write port. Once the write completes, the host no longer has to push symbols one register write at a time.

## Interface
- BASE_ADDR, default 8'h00: tone-RAM address of symbol 0; symbol k is written to BASE_ADDR+k, modulo 256.
- clk  in  1  system clock (50 MHz); all logic on negedge clk, matching the mapper.
- rst_n  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- msg  in  50  packed message, msg[49] encoded first; captured on the accepted start.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle pulse after the last symbol write.
- sym_we  out  1  tone-RAM write strobe.
- sym_addr  out  8  tone-RAM address.
- sym_dat  out  8  tone-RAM data; [1:0] is the tone, [7:2] is 0.

## Operation
- States: IDLE, ENC, WR, FIN.
- IDLE -> ENC on start: load msg into a 50-bit shift register; clear the 32-bit encoder register, the bit counter, the interleave index i (8 bits), the phase bit and the 162-bit buffer.
- Encoder input stream: 81 bits, made of msg[49..0] followed by 31 zeros.
  - Phase 0: enc = {enc[30:0], next_bit}. Emit c = parity(enc_new & 32'hF2D05351).
  - Phase 1: emit c = parity(enc & 32'hE4613C47) with no shift.
  - Total: 162 coded bits.
- ENC runs exactly 256 cycles, i = 0..255. Let j = bitrev8(i).
  - If j < 162: buf[j] <= current coded bit and the encoder advances one phase.
  - Otherwise: encoder holds.
  - Exactly 162 values of i qualify, so the stream is fully consumed at i = 255.
- ENC -> WR after i = 255; k is cleared.
- WR runs 162 cycles, k = 0..161.
  - sym_we = 1, sym_addr = BASE_ADDR + k, sym_dat = {6'b0, buf[k], SYNC[k]}.
  - SYNC is the standard WSPR 162-bit sync vector, held as a constant. It begins 1,1,0,0,0,0,0,0,1,0.
- WR -> FIN after k = 161. In FIN: done = 1 and busy = 0 for one cycle, then the block returns to IDLE.
- start is ignored whenever the state is not IDLE, including in FIN. There is no queueing.
- msg changes after capture have no effect.

## Timing
- Reset values: busy = 0, done = 0, sym_we = 0, sym_addr = BASE_ADDR, sym_dat = 0, state = IDLE.
- Start accepted on edge T:
  - busy = 1 from T+1.
  - ENC occupies T+1..T+256.
  - WR occupies T+257..T+418, one write per cycle, with no gaps.
  - done = 1 at T+419.
  - Start-to-done latency is 419 cycles.
- sym_we, sym_addr and sym_dat are registered and change together. Outside WR, sym_we = 0.
- Address wrap: BASE_ADDR = 8'hF0 gives symbol 15 at 8'hFF and symbol 16 at 8'h00.
- Reset low in any state returns the block to IDLE on that edge with sym_we = 0. No further writes or done pulse occur, and partial RAM contents are left as written.
- Reset and start in the same cycle: reset wins.

## Test plan
- All-zero msg, BASE_ADDR = 0 -> 162 writes with addr 0..161 and sym_dat == SYNC[k] (sym[0] = 1, sym[1] = 1, sym[2] = 0); done at T+419.
- msg = 50'h2_0000_0000_0000 (only msg[49] set) -> sym[0] = 3 and sym[128] = SYNC[128] + 2; full sequence matches the software model (WSJT reference encoder).
- msg "K1ABC FN42 37" -> all 162 symbols equal the reference encoder output; sym_dat[7:2] is always 0.
- start pulsed during ENC and during WR, and msg changed mid-run -> output identical to an undisturbed run; exactly one done.
- rst_n low at T+300 -> sym_we is 0 from that edge, no done; a new start afterwards produces a complete, correct run.
- BASE_ADDR = 8'hF0 -> addresses F0..FF then 00..91; total write count is 162.
